// File: rtl/parking_entry_arbiter_pkg.sv
// rtl/parking_entry_arbiter_pkg.sv - arbiter state encodings, lane indices and lane decode helper
package parking_arb_defs;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_CLEAR  = 3'd1,
    ARB_SERVE  = 3'd2,
    ARB_DONE   = 3'd3,
    ARB_LOCKED = 3'd4
  } arb_state_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  function automatic logic [1:0] lane_onehot(input logic lane);
    return (lane == LANE1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/parking_entry_arbiter_occupancy.sv
// rtl/parking_entry_arbiter_occupancy.sv - saturating lot occupancy counter with full flag
module parking_occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int OCC_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] occupancy,
  output logic             lot_full
);

  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

  logic [OCC_W-1:0] occ_q, occ_d;

  // A simultaneous entry and exit cancel out; each direction saturates on its own.
  always_comb begin
    occ_d = occ_q;
    if (inc && !dec) begin
      if (occ_q != CAP) occ_d = occ_q + 1'b1;
    end else if (dec && !inc) begin
      if (occ_q != '0) occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;
  assign lot_full  = (occ_q == CAP);

endmodule

// File: rtl/parking_entry_arbiter.sv
// rtl/parking_entry_arbiter.sv - round-robin sharing of one gate controller between two entry lanes
module parking_entry_arbiter
  import parking_arb_defs::*;
#(
  parameter int CAPACITY = 8,
  parameter int OCC_W    = 4,
  parameter int TIMEOUT  = 200,
  parameter int TO_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       lane_arrival,
  input  logic [15:0]      lane_code0,
  input  logic [15:0]      lane_code1,
  input  logic [1:0]       lane_code_ack,
  input  logic             vehicle_left,
  input  logic             vehicle_exit,
  input  logic             admin_clear,
  input  logic             ctl_open_gate,
  input  logic             ctl_close_gate,
  input  logic             ctl_blocked_gate,
  output logic             ctl_rst,
  output logic             ctl_vehicle_arrival,
  output logic [15:0]      ctl_code,
  output logic             ctl_code_ack,
  output logic             ctl_vehicle_left,
  output logic [1:0]       grant,
  output logic             lot_full,
  output logic [OCC_W-1:0] occupancy,
  output logic             lane_timeout,
  output logic             locked
);

  arb_state_e      state_q, state_d;
  logic            lane_q, lane_d;
  logic            ptr_q, ptr_d;
  logic            opened_q, opened_d;
  logic            timeout_q, timeout_d;
  logic            ctl_rst_q, ctl_rst_d;
  logic            snap_arr_q, snap_arr_d;
  logic [15:0]     snap_code_q, snap_code_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            occ_inc;
  logic            arr_g, ack_g;
  logic [15:0]     code_g;

  assign arr_g  = lane_arrival[lane_q];
  assign ack_g  = lane_code_ack[lane_q];
  assign code_g = (lane_q == LANE1) ? lane_code1 : lane_code0;

  always_comb begin
    state_d             = state_q;
    lane_d              = lane_q;
    ptr_d               = ptr_q;
    opened_d            = opened_q;
    timeout_d           = 1'b0;
    ctl_rst_d           = 1'b0;
    snap_arr_d          = snap_arr_q;
    snap_code_d         = snap_code_q;
    to_cnt_d            = to_cnt_q;
    occ_inc             = 1'b0;
    grant               = 2'b00;
    ctl_vehicle_arrival = 1'b0;
    ctl_code            = '0;
    ctl_code_ack        = 1'b0;
    ctl_vehicle_left    = 1'b0;
    locked              = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (!lot_full && (lane_arrival != 2'b00)) begin
          lane_d    = lane_arrival[ptr_q] ? ptr_q : ~ptr_q;
          ctl_rst_d = 1'b1;
          state_d   = ARB_CLEAR;
        end
      end
      ARB_CLEAR: begin
        grant    = lane_onehot(lane_q);
        to_cnt_d = '0;
        opened_d = 1'b0;
        state_d  = ARB_SERVE;
      end
      ARB_SERVE: begin
        grant               = lane_onehot(lane_q);
        ctl_vehicle_arrival = arr_g;
        ctl_code            = code_g;
        ctl_code_ack        = ack_g;
        ctl_vehicle_left    = vehicle_left;
        snap_arr_d          = arr_g;
        snap_code_d         = code_g;
        to_cnt_d            = ack_g ? '0 : to_cnt_q + 1'b1;
        if (ctl_open_gate) opened_d = 1'b1;
        // An arrival that vanishes before the gate opened means the car backed out.
        if (ctl_close_gate) begin
          occ_inc   = 1'b1;
          ctl_rst_d = 1'b1;
          state_d   = ARB_DONE;
        end else if (ctl_blocked_gate) begin
          state_d = ARB_LOCKED;
        end else if ((to_cnt_q == TO_W'(TIMEOUT)) || (!arr_g && !opened_q && !ctl_open_gate)) begin
          timeout_d = 1'b1;
          ctl_rst_d = 1'b1;
          state_d   = ARB_DONE;
        end
      end
      ARB_DONE: begin
        ptr_d   = ~lane_q;
        state_d = ARB_IDLE;
      end
      ARB_LOCKED: begin
        grant               = lane_onehot(lane_q);
        ctl_vehicle_arrival = snap_arr_q;
        ctl_code            = snap_code_q;
        locked              = 1'b1;
        if (admin_clear) begin
          ctl_rst_d = 1'b1;
          state_d   = ARB_DONE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      lane_q      <= LANE0;
      ptr_q       <= LANE0;
      opened_q    <= 1'b0;
      timeout_q   <= 1'b0;
      ctl_rst_q   <= 1'b1;
      snap_arr_q  <= 1'b0;
      snap_code_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      ptr_q       <= ptr_d;
      opened_q    <= opened_d;
      timeout_q   <= timeout_d;
      ctl_rst_q   <= ctl_rst_d;
      snap_arr_q  <= snap_arr_d;
      snap_code_q <= snap_code_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign ctl_rst      = ctl_rst_q;
  assign lane_timeout = timeout_q;

  parking_occupancy_counter #(
    .CAPACITY (CAPACITY),
    .OCC_W    (OCC_W)
  ) u_occ (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (occ_inc),
    .dec       (vehicle_exit),
    .occupancy (occupancy),
    .lot_full  (lot_full)
  );

endmodule

// File: tb/tb_parking_entry_arbiter.sv
// tb/tb_parking_entry_arbiter.sv - randomized session-level bench for the entry arbiter
module tb_parking_entry_arbiter;

  localparam int CAP = 8;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  lane_arrival, lane_code_ack;
  logic [15:0] lane_code0, lane_code1;
  logic        vehicle_left, vehicle_exit, admin_clear;
  logic        ctl_open_gate, ctl_close_gate, ctl_blocked_gate;
  logic        ctl_rst, ctl_vehicle_arrival, ctl_code_ack, ctl_vehicle_left;
  logic [15:0] ctl_code;
  logic [1:0]  grant;
  logic        lot_full, lane_timeout, locked;
  logic [3:0]  occupancy;

  int errs   = 0;
  int checks = 0;
  int m_occ  = 0;
  int m_ptr  = 0;

  parking_entry_arbiter #(
    .CAPACITY (CAP),
    .OCC_W    (4),
    .TIMEOUT  (TMO),
    .TO_W     (8)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lane_arrival        (lane_arrival),
    .lane_code0          (lane_code0),
    .lane_code1          (lane_code1),
    .lane_code_ack       (lane_code_ack),
    .vehicle_left        (vehicle_left),
    .vehicle_exit        (vehicle_exit),
    .admin_clear         (admin_clear),
    .ctl_open_gate       (ctl_open_gate),
    .ctl_close_gate      (ctl_close_gate),
    .ctl_blocked_gate    (ctl_blocked_gate),
    .ctl_rst             (ctl_rst),
    .ctl_vehicle_arrival (ctl_vehicle_arrival),
    .ctl_code            (ctl_code),
    .ctl_code_ack        (ctl_code_ack),
    .ctl_vehicle_left    (ctl_vehicle_left),
    .grant               (grant),
    .lot_full            (lot_full),
    .occupancy           (occupancy),
    .lane_timeout        (lane_timeout),
    .locked              (locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick_lane(input int mask);
    return (((mask >> m_ptr) & 1) != 0) ? m_ptr : 1 - m_ptr;
  endfunction

  // Entered and left in an IDLE cycle. outcome: 0 close, 1 ack timeout, 2 arrival drop, 3 blocked.
  task automatic run_session(input logic [1:0] mask, input int outcome, input bit exit_with_close);
    int          lane;
    int          n;
    logic [15:0] code;
    lane = pick_lane(int'(mask));
    code = 16'($urandom);
    lane_code0   = (lane == 0) ? code : 16'($urandom);
    lane_code1   = (lane == 1) ? code : 16'($urandom);
    lane_arrival = mask;
    #1 chk("idle_grant", grant, 0);
    tick();
    chk("clear_grant", grant, 32'(1 << lane));
    chk("clear_rst", ctl_rst, 1);
    chk("clear_code", ctl_code, 0);
    tick();
    chk("serve_code", ctl_code, code);
    chk("serve_arr", ctl_vehicle_arrival, 1);
    chk("serve_rst", ctl_rst, 0);
    lane_code_ack = 2'(1 << (1 - lane));
    #1 chk("other_ack", ctl_code_ack, 0);
    tick();
    lane_code_ack = 2'(1 << lane);
    #1 chk("own_ack", ctl_code_ack, 1);
    tick();
    lane_code_ack = 2'b00;
    case (outcome)
      0: begin
        vehicle_left = 1'b1;
        #1 chk("left_fwd", ctl_vehicle_left, 1);
        ctl_open_gate = 1'b1;
        tick();
        ctl_open_gate  = 1'b0;
        vehicle_left   = 1'b0;
        ctl_close_gate = 1'b1;
        vehicle_exit   = exit_with_close;
        tick();
        ctl_close_gate = 1'b0;
        vehicle_exit   = 1'b0;
        if (!exit_with_close) m_occ++;
        chk("done_grant", grant, 0);
        chk("done_rst", ctl_rst, 1);
        chk("done_occ", occupancy, 32'(m_occ));
      end
      1: begin
        n = 1;
        while (!lane_timeout && n < TMO + 10) begin
          tick();
          n++;
        end
        // Counter clears on the ack, counts TIMEOUT cycles, and the pulse shows in DONE.
        chk("to_latency", 32'(n), 32'(TMO + 2));
        chk("to_occ", occupancy, 32'(m_occ));
        chk("to_grant", grant, 0);
      end
      2: begin
        lane_arrival = mask & ~2'(1 << lane);
        tick();
        chk("drop_to", lane_timeout, 1);
        chk("drop_occ", occupancy, 32'(m_occ));
      end
      default: begin
        ctl_blocked_gate = 1'b1;
        tick();
        ctl_blocked_gate = 1'b0;
        lane_arrival     = 2'b11;
        chk("lock_flag", locked, 1);
        chk("lock_grant", grant, 32'(1 << lane));
        lane_code0 = 16'($urandom);
        lane_code1 = 16'($urandom);
        repeat ($urandom_range(2, 6)) tick();
        chk("lock_hold", grant, 32'(1 << lane));
        chk("lock_code", ctl_code, code);
        admin_clear = 1'b1;
        tick();
        admin_clear = 1'b0;
        chk("unlock_flag", locked, 0);
        chk("unlock_grant", grant, 0);
      end
    endcase
    m_ptr = 1 - lane;
    tick();
    chk("pulse_width", lane_timeout, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    lane_arrival = 2'b00; lane_code_ack = 2'b00;
    lane_code0 = '0; lane_code1 = '0;
    vehicle_left = 1'b0; vehicle_exit = 1'b0; admin_clear = 1'b0;
    ctl_open_gate = 1'b0; ctl_close_gate = 1'b0; ctl_blocked_gate = 1'b0;
    tick();
    tick();
    chk("rst_ctl_rst", ctl_rst, 1);
    chk("rst_grant", grant, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_code", ctl_code, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ctl_rst", ctl_rst, 0);

    run_session(2'b01, 0, 1'b0);
    run_session(2'b11, 0, 1'b0);
    run_session(2'b11, 0, 1'b0);

    lane_arrival = 2'b01;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_occ", occupancy, 0);
    chk("async_ctl_rst", ctl_rst, 1);
    chk("async_code", ctl_code, 0);
    chk("async_arr", ctl_vehicle_arrival, 0);
    tick();
    rst_n = 1'b1;
    lane_arrival = 2'b00;
    m_occ = 0;
    m_ptr = 0;
    tick();

    run_session(2'b11, 3, 1'b0);
    run_session(2'b11, 0, 1'b0);
    run_session(2'b11, 1, 1'b0);
    run_session(2'b01, 2, 1'b0);
    run_session(2'b10, 0, 1'b1);

    while (m_occ < CAP) run_session(2'($urandom_range(1, 3)), 0, 1'b0);
    lane_arrival = 2'b01;
    repeat (3) tick();
    chk("full_flag", lot_full, 1);
    chk("full_grant", grant, 0);
    chk("full_occ", occupancy, 32'(CAP));
    vehicle_exit = 1'b1;
    tick();
    vehicle_exit = 1'b0;
    m_occ--;
    chk("exit_occ", occupancy, 32'(m_occ));
    chk("exit_flag", lot_full, 0);
    run_session(2'b01, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      int r;
      if (m_occ == CAP) begin
        lane_arrival = 2'b00;
        vehicle_exit = 1'b1;
        tick();
        vehicle_exit = 1'b0;
        m_occ--;
        chk("rnd_exit_occ", occupancy, 32'(m_occ));
      end
      r = $urandom_range(0, 9);
      run_session(2'($urandom_range(1, 3)),
                  (r < 6) ? 0 : (r == 6) ? 1 : (r < 9) ? 2 : 3,
                  ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
